// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline.
// Holds the datapath widths, the ALU opcode encoding and the state
// encoding of the execute-stage multiply sequencer.
package pipe_pkg;

    localparam int DSIZE = 16;
    localparam int ISIZE = 16;
    localparam int ASIZE = 4;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_LW  = 4'd8;
    localparam logic [3:0] OP_SW  = 4'd9;
    localparam logic [3:0] OP_BEQ = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/exe_mem_if.sv
// ID/EXE -> EX/MEM boundary of the pipeline.
// Carries the decoded operands and control into the execute stage and the
// registered EX/MEM values plus the upstream stall back out.
//   master : upstream side (drives the *_in signals, observes the *_out ones)
//   slave  : the execute stage itself
interface exe_mem_if;
    import pipe_pkg::*;

    logic [DSIZE-1:0] rdata1_in;
    logic [DSIZE-1:0] rdata2_in;
    logic [DSIZE-1:0] imm_in;
    logic [3:0]       opcode_in;
    logic             alusrc_in;
    logic [ASIZE-1:0] waddr_in;
    logic             branch_in;
    logic             memRead_in;
    logic             memWrite_in;
    logic             memtoReg_in;
    logic             wen_in;
    logic [ISIZE-1:0] pc_in;

    logic [DSIZE-1:0] alu_result_out;
    logic [DSIZE-1:0] store_data_out;
    logic [ASIZE-1:0] waddr_out;
    logic             memRead_out;
    logic             memWrite_out;
    logic             memtoReg_out;
    logic             wen_out;
    logic             branch_taken_out;
    logic [ISIZE-1:0] branch_target_out;
    logic             stall_out;

    modport master (
        output rdata1_in, rdata2_in, imm_in, opcode_in, alusrc_in, waddr_in,
               branch_in, memRead_in, memWrite_in, memtoReg_in, wen_in, pc_in,
        input  alu_result_out, store_data_out, waddr_out, memRead_out,
               memWrite_out, memtoReg_out, wen_out, branch_taken_out,
               branch_target_out, stall_out
    );

    modport slave (
        input  rdata1_in, rdata2_in, imm_in, opcode_in, alusrc_in, waddr_in,
               branch_in, memRead_in, memWrite_in, memtoReg_in, wen_in, pc_in,
        output alu_result_out, store_data_out, waddr_out, memRead_out,
               memWrite_out, memtoReg_out, wen_out, branch_taken_out,
               branch_target_out, stall_out
    );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier producing the low DSIZE bits of a x b.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : latch a/b, clear the step counter and begin
//   a, b     : operands, sampled on start
//   busy     : a multiply is in progress (one step per cycle)
//   done     : high during the final step; product is valid after that edge
//   product  : accumulated product
module seq_multiplier
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DSIZE-1:0] a,
    input  logic [DSIZE-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [DSIZE-1:0] product
);

    logic [DSIZE-1:0] mcand;
    logic [DSIZE-1:0] mplier;
    logic [DSIZE-1:0] acc;
    logic [3:0]       count;
    logic             running;

    // Each step adds the shifted multiplicand when the current multiplier
    // bit is set; 16 steps cover every bit, truncation gives the low half.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 4'd1;
            if (count == 4'd15) begin
                running <= 1'b0;
            end
        end
    end

    assign busy    = running;
    assign done    = running && (count == 4'd15);
    assign product = acc;

endmodule

// File: rtl/exe_mem_stage.sv
// Execute stage plus EX/MEM pipeline register.
// Computes the ALU result / memory address and branch decision from the
// ID/EXE values and registers them with the MEM/WB control. MUL runs on a
// 16-step shift-add unit while stall_out freezes the upstream stages and
// the EX/MEM register takes bubbles.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : exe_mem_if slave (ID/EXE inputs, EX/MEM outputs, stall_out)
module exe_mem_stage
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    exe_mem_if.slave   bus
);

    mul_state_t       state;
    mul_state_t       next_state;
    logic             valid_mul;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [DSIZE-1:0] mul_product;
    logic             load_bubble;
    logic             use_product;
    logic [DSIZE-1:0] op_b;
    logic [DSIZE-1:0] alu_calc;
    logic             taken;
    logic [ISIZE-1:0] target;

    // Opcode 7 without a register write is not a multiply; it becomes a bubble.
    assign valid_mul = (bus.opcode_in == OP_MUL) && bus.wen_in;
    assign mul_start = (state == ST_IDLE) && valid_mul;
    assign op_b      = bus.alusrc_in ? bus.imm_in : bus.rdata2_in;

    seq_multiplier u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.rdata1_in),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE always returns to IDLE, so the still-held MUL is not restarted.
    // Leaving BUSY without a done pulse cannot happen in normal operation;
    // it only recovers the FSM if the multiplier ever stops early.
    always_comb begin
        next_state  = state;
        load_bubble = 1'b0;
        use_product = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_mul) begin
                    next_state  = ST_BUSY;
                    load_bubble = 1'b1;
                end
            end
            ST_BUSY: begin
                load_bubble = 1'b1;
                if (mul_done) begin
                    next_state = ST_DONE;
                end else if (!mul_busy) begin
                    next_state = ST_IDLE;
                end
            end
            ST_DONE: begin
                use_product = 1'b1;
                next_state  = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign bus.stall_out = mul_start || (state == ST_BUSY);

    // Loads and stores add the immediate regardless of alusrc_in.
    always_comb begin
        alu_calc = '0;
        case (bus.opcode_in)
            OP_ADD:        alu_calc = bus.rdata1_in + op_b;
            OP_SUB:        alu_calc = bus.rdata1_in - op_b;
            OP_AND:        alu_calc = bus.rdata1_in & op_b;
            OP_OR:         alu_calc = bus.rdata1_in | op_b;
            OP_XOR:        alu_calc = bus.rdata1_in ^ op_b;
            OP_SLL:        alu_calc = bus.rdata1_in << op_b[3:0];
            OP_SRL:        alu_calc = bus.rdata1_in >> op_b[3:0];
            OP_LW, OP_SW:  alu_calc = bus.rdata1_in + bus.imm_in;
            default:       alu_calc = '0;
        endcase
    end

    assign taken  = bus.branch_in && (bus.rdata1_in == bus.rdata2_in);
    assign target = taken ? (bus.pc_in + ISIZE'(1) + bus.imm_in) : '0;

    always_ff @(posedge clk) begin
        if (rst || load_bubble || ((bus.opcode_in == OP_MUL) && !bus.wen_in)) begin
            bus.alu_result_out    <= '0;
            bus.store_data_out    <= '0;
            bus.waddr_out         <= '0;
            bus.memRead_out       <= 1'b0;
            bus.memWrite_out      <= 1'b0;
            bus.memtoReg_out      <= 1'b0;
            bus.wen_out           <= 1'b0;
            bus.branch_taken_out  <= 1'b0;
            bus.branch_target_out <= '0;
        end else begin
            bus.alu_result_out    <= use_product ? mul_product : alu_calc;
            bus.store_data_out    <= bus.rdata2_in;
            bus.waddr_out         <= bus.waddr_in;
            bus.memRead_out       <= bus.memRead_in;
            bus.memWrite_out      <= bus.memWrite_in;
            bus.memtoReg_out      <= bus.memtoReg_in;
            bus.wen_out           <= bus.wen_in;
            bus.branch_taken_out  <= taken;
            bus.branch_target_out <= target;
        end
    end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_exe_mem_stage;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int   check_count;
    int   fail_count;

    exe_mem_if bus ();

    exe_mem_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output bundle: {alu, store, waddr, memRead, memWrite, memtoReg, wen, taken, target}
    function automatic logic [63:0] observed();
        return {7'd0, bus.alu_result_out, bus.store_data_out, bus.waddr_out,
                bus.memRead_out, bus.memWrite_out, bus.memtoReg_out, bus.wen_out,
                bus.branch_taken_out, bus.branch_target_out};
    endfunction

    // Reference: what the EX/MEM register should hold for one instruction.
    function automatic logic [63:0] refModel(
        input logic [15:0] a, input logic [15:0] b2, input logic [15:0] imm,
        input logic [3:0] op, input logic alusrc, input logic [3:0] waddr,
        input logic br, input logic mr, input logic mw, input logic mt,
        input logic wen, input logic [15:0] pc);
        int unsigned bv;
        int unsigned av;
        int unsigned res;
        logic        tk;
        int unsigned tgt;
        av  = a;
        bv  = alusrc ? imm : b2;
        case (op)
            4'd0:       res = av + bv;
            4'd1:       res = av + 65536 - bv;
            4'd2:       res = av & bv;
            4'd3:       res = av | bv;
            4'd4:       res = av ^ bv;
            4'd5:       res = av * (1 << (bv % 16));
            4'd6:       res = av / (1 << (bv % 16));
            4'd7:       res = av * bv;
            4'd8, 4'd9: res = av + imm;
            default:    res = 0;
        endcase
        res = res % 65536;
        if (op == 4'd7 && !wen) return 64'd0;
        tk  = br && (a == b2);
        tgt = tk ? (pc + 1 + imm) % 65536 : 0;
        return {7'd0, res[15:0], b2, waddr, mr, mw, mt, wen, tk, tgt[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic driveInputs(
        input logic [15:0] a, input logic [15:0] b2, input logic [15:0] imm,
        input logic [3:0] op, input logic alusrc, input logic [3:0] waddr,
        input logic br, input logic mr, input logic mw, input logic mt,
        input logic wen, input logic [15:0] pc);
        bus.rdata1_in   = a;
        bus.rdata2_in   = b2;
        bus.imm_in      = imm;
        bus.opcode_in   = op;
        bus.alusrc_in   = alusrc;
        bus.waddr_in    = waddr;
        bus.branch_in   = br;
        bus.memRead_in  = mr;
        bus.memWrite_in = mw;
        bus.memtoReg_in = mt;
        bus.wen_in      = wen;
        bus.pc_in       = pc;
    endtask

    // Presents one instruction, holds it while the stage stalls, and checks
    // every EX/MEM value and the stall line along the way.
    task automatic applyStimulus(
        input string tag,
        input logic [15:0] a, input logic [15:0] b2, input logic [15:0] imm,
        input logic [3:0] op, input logic alusrc, input logic [3:0] waddr,
        input logic br, input logic mr, input logic mw, input logic mt,
        input logic wen, input logic [15:0] pc);
        logic [63:0] exp;
        exp = refModel(a, b2, imm, op, alusrc, waddr, br, mr, mw, mt, wen, pc);
        driveInputs(a, b2, imm, op, alusrc, waddr, br, mr, mw, mt, wen, pc);
        #1;
        if (op == 4'd7 && wen) begin
            for (int k = 0; k < 17; k++) begin
                checkOutput({tag, "_stall_hi"}, 64'(bus.stall_out), 64'd1);
                @(posedge clk);
                #1;
                checkOutput({tag, "_bubble"}, observed(), 64'd0);
            end
        end
        checkOutput({tag, "_stall_lo"}, 64'(bus.stall_out), 64'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_result"}, observed(), exp);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [3:0]  rop;
        logic        rwen;
        check_count = 0;
        fail_count  = 0;

        rst = 1'b1;
        driveInputs(16'h0, 16'h0, 16'h0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", observed(), 64'd0);
        checkOutput("reset_stall", 64'(bus.stall_out), 64'd0);
        rst = 1'b0;

        $display("[TB] directed cases");
        applyStimulus("add", 16'h1234, 16'h0F0F, 16'h0, OP_ADD, 1'b0, 4'd3, 0, 0, 0, 0, 1, 16'h0);
        checkOutput("add_value", 64'(bus.alu_result_out), 64'h2143);
        applyStimulus("lw", 16'h0010, 16'h0, 16'hFFFE, OP_LW, 1'b1, 4'd4, 0, 1, 0, 1, 1, 16'h0);
        checkOutput("lw_value", 64'(bus.alu_result_out), 64'h000E);
        applyStimulus("beq_taken", 16'd5, 16'd5, 16'h0004, OP_BEQ, 1'b0, 4'd0, 1, 0, 0, 0, 0, 16'h0020);
        checkOutput("beq_target", 64'({bus.branch_taken_out, bus.branch_target_out}), 64'h10025);
        applyStimulus("beq_not_taken", 16'd5, 16'd6, 16'h0004, OP_BEQ, 1'b0, 4'd0, 1, 0, 0, 0, 0, 16'h0020);
        checkOutput("beq_nt_flag", 64'(bus.branch_taken_out), 64'd0);
        applyStimulus("mul300", 16'd300, 16'd300, 16'h0, OP_MUL, 1'b0, 4'd5, 0, 0, 0, 0, 1, 16'h0);
        checkOutput("mul300_value", 64'({bus.wen_out, bus.alu_result_out}), 64'h15F90);
        applyStimulus("b2b_mul", 16'd7, 16'd9, 16'h0, OP_MUL, 1'b0, 4'd6, 0, 0, 0, 0, 1, 16'h0);
        applyStimulus("b2b_sub", 16'd7, 16'd9, 16'h0, OP_SUB, 1'b0, 4'd6, 0, 0, 0, 0, 1, 16'h0);
        checkOutput("b2b_sub_value", 64'(bus.alu_result_out), 64'hFFFE);
        applyStimulus("mul_nowen", 16'd3, 16'd4, 16'h0, OP_MUL, 1'b0, 4'd2, 0, 0, 0, 0, 0, 16'h0);

        // Abandon a multiply part way through BUSY (counter at 8).
        driveInputs(16'd300, 16'd300, 16'h0, OP_MUL, 1'b0, 4'd9, 0, 0, 0, 0, 1, 16'h0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("rst_mid_stall", 64'(bus.stall_out), 64'd1);
        rst = 1'b1;
        driveInputs(16'd3, 16'd4, 16'h0, OP_ADD, 1'b0, 4'd1, 0, 0, 0, 0, 1, 16'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_mid_outputs", observed(), 64'd0);
        checkOutput("rst_mid_stall_lo", 64'(bus.stall_out), 64'd0);
        rst = 1'b0;
        applyStimulus("post_rst_add", 16'd3, 16'd4, 16'h0, OP_ADD, 1'b0, 4'd1, 0, 0, 0, 0, 1, 16'h0);
        driveInputs(16'h0, 16'h0, 16'h0, 4'd11, 1'b0, 4'd0, 0, 0, 0, 0, 0, 16'h0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            checkOutput("no_ghost_product", observed(), 64'd0);
        end

        $display("[TB] random cases");
        for (int n = 0; n < 40; n++) begin
            ra   = 16'($urandom);
            rb   = ($urandom_range(0, 2) == 0) ? ra : 16'($urandom);
            rwen = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                rop  = OP_MUL;
                rwen = 1'b1;
            end else begin
                rop = 4'($urandom_range(0, 15));
            end
            applyStimulus("rand", ra, rb, 16'($urandom), rop, 1'($urandom),
                          4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), rwen, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage.md
# exe_mem_stage

Execute stage plus EX/MEM pipeline register of the 16-bit five-stage pipeline. It consumes the ID/EXE register outputs and computes the ALU result, load/store address and branch decision. It registers all of these, together with the MEM/WB control, for the memory stage. MUL runs on a multi-cycle shift-add unit; while it runs, `stall_out` holds IF, ID and ID/EXE, and the EX/MEM register receives bubbles.

## Interface
- `DSIZE`, 16, data width
- `ISIZE`, 16, PC width (word address)
- `ASIZE`, 4, register address width
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `rdata1_in`, `rdata2_in` in DSIZE: register operands
- `imm_in` in DSIZE: sign-extended immediate
- `opcode_in` in 4: operation
- `alusrc_in` in 1: operand B select, 1 = `imm_in`, 0 = `rdata2_in`
- `waddr_in` in ASIZE: destination register
- `branch_in`, `memRead_in`, `memWrite_in`, `memtoReg_in`, `wen_in` in 1: control
- `pc_in` in ISIZE: PC of the instruction
- `alu_result_out` out DSIZE: result or memory address
- `store_data_out` out DSIZE: registered `rdata2_in`
- `waddr_out` out ASIZE
- `memRead_out`, `memWrite_out`, `memtoReg_out`, `wen_out` out 1
- `branch_taken_out` out 1: registered taken branch
- `branch_target_out` out ISIZE
- `stall_out` out 1: combinational, hold upstream stages

## Operation
- Operand B = `alusrc_in ? imm_in : rdata2_in`. All arithmetic is modulo 2^16 and unsigned unless stated.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A−B
  - 2 AND, 3 OR, 4 XOR
  - 5 SLL: A<<B[3:0]
  - 6 SRL (logical): A>>B[3:0]
  - 7 MUL: low 16 bits of A×B
  - 8 LW, 9 SW: A+imm
  - 10 BEQ: result 0
  - 11–15: result 0
- Branch: taken = `branch_in` & (`rdata1_in` == `rdata2_in`). Target = `pc_in` + 1 + `imm_in`. When not taken, `branch_target_out` = 0.
- A bubble is every control output 0, `alu_result_out`, `waddr_out` and `store_data_out` 0, and `branch_taken_out` 0.
- MUL is recognised only when `opcode_in`==7 and `wen_in`==1. Opcode 7 with `wen_in`==0 is a bubble and never triggers the FSM.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, valid MUL present: latch the operands, clear the 4-bit counter, go to BUSY, load a bubble into EX/MEM.
  - IDLE, anything else: EX/MEM loads the computed values.
  - BUSY: one shift-add step per cycle, counter +1. When the counter is 15, go to DONE. EX/MEM loads a bubble.
  - DONE: EX/MEM loads the product with the held MUL control and `waddr_in`, then go to IDLE. A held MUL is not re-accepted in DONE.
- `stall_out` = (IDLE & valid MUL) | BUSY. It is low in DONE.
- Reset:
  - All outputs 0, FSM to IDLE, counter 0.
  - Reset in BUSY or DONE abandons the multiply; no product is written.
  - Reset overrides every other event.

## Timing
- Non-MUL: inputs sampled at edge N, outputs valid after edge N. Latency 1.
- MUL presented before edge N:
  - Edge N: to BUSY.
  - Edges N+1..N+16: 16 steps, then to DONE.
  - Edge N+17: product registered.
  - `stall_out` is high for 17 cycles (before edges N..N+16).
  - Upstream holds the ID/EXE inputs stable throughout; the block relies on this.
- Back-to-back MULs: the second one is seen in IDLE at edge N+18 and restarts with the same timing. There is no overlap.
- `branch_taken_out` is registered. Flushing the younger IF/ID instructions is the hazard unit's job, triggered from this output.

## Structure
- Shared package `pipe_pkg` holds:
  - the DSIZE, ISIZE and ASIZE constants
  - the opcode constants OP_ADD..OP_BEQ
  - the FSM state encoding
- One sub-module: `seq_multiplier` (shift-add).
  - Ports: start, A, B, busy, done, product.
  - Its counter and operand registers live inside it.
- ALU and branch compare are combinational inside `exe_mem_stage`.

## Test plan
- ADD: A=0x1234, B=0x0F0F (`alusrc_in`=0, `wen_in`=1) -> after 1 edge `alu_result_out`=0x2143, `wen_out`=1, `stall_out` never high.
- LW: A=0x0010, imm=0xFFFE, `memRead_in`=1, `memtoReg_in`=1 -> `alu_result_out`=0x000E, `memRead_out`=1, `memtoReg_out`=1.
- BEQ: `rdata1_in`=`rdata2_in`=5, `pc_in`=0x0020, imm=0x0004 -> `branch_taken_out`=1, `branch_target_out`=0x0025. With operands 5 and 6 -> `branch_taken_out`=0.
- MUL 300×300, held 17 cycles -> `stall_out` high for exactly 17 cycles, bubbles meanwhile, then `alu_result_out`=0x5F90 (24464) with `wen_out`=1 one edge after `stall_out` falls.
- Reset at BUSY count 8 -> the next edge gives all outputs 0 and `stall_out`=0. An ADD presented next completes in 1 cycle, and no product ever appears.
- MUL then SUB 7−9 back-to-back -> product first, SUB result 0xFFFE on the following edge, and no duplicate MUL.
